// File: rtl/updown_count_scheduler.sv
// updown_count_scheduler
// Two requesters submit multi-step up/down commands. A round-robin arbiter
// accepts one command at a time, and an FSM replays it as single-cycle
// up/down steps into an embedded WIDTH-bit counter. Completion is reported
// with a one-cycle done pulse, together with the requester id and a
// saturation flag.
//
// Handshake (per requester i): a command transfers on a rising edge where
// req_valid[i] and req_ready[i] are both high. req_ready is combinational,
// is at most one-hot, is offered only in IDLE and is held low during reset.
// Once the requester raises req_valid it keeps req_dir[i] and its req_steps
// field stable until the transfer. req_valid may be dropped before the
// transfer with no effect. Inputs seen in RUN or DONE are ignored.
module updown_count_scheduler #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_dir,
    input  logic [2*STEP_W-1:0] req_steps,
    input  logic                sat_mode,
    output logic [1:0]          req_ready,
    output logic                up,
    output logic                down,
    output logic [WIDTH-1:0]    cnt,
    output logic [WIDTH-1:0]    inverted_cnt,
    output logic                busy,
    output logic                done,
    output logic                done_id,
    output logic                sat_hit,
    output logic [1:0]          fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0]  CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]  CNT_MIN   = {WIDTH{1'b0}};
    localparam logic [STEP_W-1:0] NO_STEPS  = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] LAST_STEP = {{(STEP_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic              rr_ptr;      // requester that wins when both are valid
    logic              cmd_dir;     // latched direction, 1 = up
    logic              cmd_sat;     // latched sat_mode
    logic              cmd_id;      // latched requester index
    logic [STEP_W-1:0] remaining;   // steps still to replay, including this cycle's
    logic              sat_flag;    // some step of this command was suppressed

    logic              grant_any;
    logic              grant_id;
    logic              grant_dir;
    logic [STEP_W-1:0] grant_steps;
    logic              at_bound;
    logic              step_blocked;

    // Arbitration: single valid requester wins outright, a tie goes to rr_ptr.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (!reset && state == IDLE) begin
            case (req_valid)
                2'b01: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b0;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b1;
                end
                2'b11: begin
                    grant_any = 1'b1;
                    grant_id  = rr_ptr;
                end
                default: begin
                    grant_any = 1'b0;
                    grant_id  = 1'b0;
                end
            endcase
        end
    end

    // The granted requester always has valid high, so a grant is an accept.
    assign req_ready   = {grant_any & grant_id, grant_any & ~grant_id};
    assign grant_dir   = req_dir[grant_id];
    assign grant_steps = grant_id ? req_steps[2*STEP_W-1:STEP_W]
                                  : req_steps[STEP_W-1:0];

    // A step is suppressed when saturating and the counter already sits at
    // the bound it is heading towards.
    assign at_bound     = cmd_dir ? (cnt == CNT_MAX) : (cnt == CNT_MIN);
    assign step_blocked = cmd_sat & at_bound;

    assign inverted_cnt = ~cnt;
    assign busy         = (state == RUN) || (state == DONE);
    assign fsm_state    = state;

    // Control FSM: IDLE accepts, RUN replays steps, DONE holds for the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state <= (grant_steps == NO_STEPS) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (remaining == LAST_STEP || remaining == NO_STEPS) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle raises done; the second returns to IDLE.
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Latch the accepted command and count down the steps still to replay.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_dir   <= 1'b0;
            cmd_sat   <= 1'b0;
            cmd_id    <= 1'b0;
            remaining <= NO_STEPS;
        end else if (state == IDLE && grant_any) begin
            cmd_dir   <= grant_dir;
            cmd_sat   <= sat_mode;
            cmd_id    <= grant_id;
            remaining <= grant_steps;
        end else if (state == RUN && remaining != NO_STEPS) begin
            remaining <= remaining - 1'b1;
        end
    end

    // Round-robin pointer hands priority to the other requester after any accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && grant_any) begin
            rr_ptr <= ~grant_id;
        end
    end

    // Counter and its step pulses, registered together so a pulse and the
    // counter value it produced are visible in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= CNT_MIN;
            up   <= 1'b0;
            down <= 1'b0;
        end else begin
            up   <= 1'b0;
            down <= 1'b0;
            if (state == RUN && !step_blocked) begin
                if (cmd_dir) begin
                    cnt <= cnt + 1'b1;
                    up  <= 1'b1;
                end else begin
                    cnt  <= cnt - 1'b1;
                    down <= 1'b1;
                end
            end
        end
    end

    // Sticky saturation flag for the command in flight, cleared as DONE exits.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_flag <= 1'b0;
        end else if (state == RUN && step_blocked) begin
            sat_flag <= 1'b1;
        end else if (state == DONE && done) begin
            sat_flag <= 1'b0;
        end
    end

    // Completion report: a single-cycle done with id and saturation status.
    always_ff @(posedge clk) begin
        if (reset) begin
            done    <= 1'b0;
            done_id <= 1'b0;
            sat_hit <= 1'b0;
        end else if (state == DONE && !done) begin
            done    <= 1'b1;
            done_id <= cmd_id;
            sat_hit <= sat_flag;
        end else begin
            done    <= 1'b0;
            sat_hit <= 1'b0;
        end
    end

endmodule
